// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between the icache and dcache
// refill engines: one AR at a time, R beats steered back to the granted requester.
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_i_rreq,
  input  logic [ADDR_W-1:0] io_i_raddr,
  input  logic [LEN_W-1:0]  io_i_rlen,
  output logic              io_i_ack,
  output logic              io_i_rvalid,
  input  logic              io_d_rreq,
  input  logic [ADDR_W-1:0] io_d_raddr,
  input  logic [LEN_W-1:0]  io_d_rlen,
  output logic              io_d_ack,
  output logic              io_d_rvalid,
  output logic [DATA_W-1:0] io_ret_rdata,
  output logic              io_ret_rlast,
  output logic              io_ret_rerr,
  output logic [ADDR_W-1:0] io_araddr,
  output logic [LEN_W-1:0]  io_arlen,
  output logic [2:0]        io_arsize,
  output logic [1:0]        io_arburst,
  output logic              io_arvalid,
  input  logic              io_arready,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic [1:0]        io_rresp,
  input  logic              io_rvalid,
  output logic              io_rready,
  input  logic              io_rlast,
  output logic [1:0]        dbg_state
);

  // Handshakes: AR transfers when io_arvalid && io_arready, R beats transfer when
  // io_rvalid && io_rready; a request is consumed in the cycle its io_x_ack is high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_grant;  // 1 = dcache, 0 = icache
  logic              owner;       // 1 = dcache, 0 = icache
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    cnt;
  logic              i_win, d_win, grant, beat;

  always_comb begin
    i_win = io_i_rreq && (!io_d_rreq || last_grant);
    d_win = io_d_rreq && (!io_i_rreq || !last_grant);
    grant = (state == S_IDLE) && (i_win || d_win);
    beat  = (state == S_R) && io_rvalid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_win || d_win) state_nxt = S_AR;
      S_AR:    if (io_arready) state_nxt = S_R;
      S_R:     if (beat && io_rlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_i_ack     = grant && i_win;
    io_d_ack     = grant && d_win;
    io_arvalid   = (state == S_AR);
    io_araddr    = addr_q;
    io_arlen     = len_q;
    io_arsize    = 3'b010;
    io_arburst   = 2'b01;
    io_rready    = (state == S_R);
    io_i_rvalid  = beat && !owner;
    io_d_rvalid  = beat && owner;
    io_ret_rdata = io_rdata;
    io_ret_rlast = io_rlast;
    // Flag bad responses and any beat whose rlast disagrees with the requested length.
    io_ret_rerr  = beat && ((io_rresp != 2'b00) ||
                            (io_rlast && (cnt != {1'b0, len_q})) ||
                            (!io_rlast && (cnt >= {1'b0, len_q})));
    dbg_state    = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b0;
      owner      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
    end else begin
      if (grant) begin
        owner  <= d_win;
        addr_q <= d_win ? io_d_raddr : io_i_raddr;
        len_q  <= d_win ? io_d_rlen  : io_i_rlen;
      end
      if (beat) begin
        if (io_rlast) begin
          cnt        <= '0;
          last_grant <= owner;
        end else if (cnt != '1) begin
          cnt <= cnt + (LEN_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: scenario tasks drive requests and R beats; a negedge
// monitor pops expected beats {is_d, err, last, data} from a scoreboard queue.
module tb_axi_read_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_i_rreq = 1'b0;
  logic [ADDR_W-1:0] io_i_raddr = '0;
  logic [LEN_W-1:0]  io_i_rlen = '0;
  logic              io_i_ack, io_i_rvalid;
  logic              io_d_rreq = 1'b0;
  logic [ADDR_W-1:0] io_d_raddr = '0;
  logic [LEN_W-1:0]  io_d_rlen = '0;
  logic              io_d_ack, io_d_rvalid;
  logic [DATA_W-1:0] io_ret_rdata;
  logic              io_ret_rlast, io_ret_rerr;
  logic [ADDR_W-1:0] io_araddr;
  logic [LEN_W-1:0]  io_arlen;
  logic [2:0]        io_arsize;
  logic [1:0]        io_arburst;
  logic              io_arvalid;
  logic              io_arready = 1'b0;
  logic [DATA_W-1:0] io_rdata = '0;
  logic [1:0]        io_rresp = '0;
  logic              io_rvalid = 1'b0;
  logic              io_rready;
  logic              io_rlast = 1'b0;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses_i = 0;
  logic [DATA_W+2:0] exp_q[$];

  axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .io_i_rreq(io_i_rreq), .io_i_raddr(io_i_raddr), .io_i_rlen(io_i_rlen),
    .io_i_ack(io_i_ack), .io_i_rvalid(io_i_rvalid),
    .io_d_rreq(io_d_rreq), .io_d_raddr(io_d_raddr), .io_d_rlen(io_d_rlen),
    .io_d_ack(io_d_ack), .io_d_rvalid(io_d_rvalid),
    .io_ret_rdata(io_ret_rdata), .io_ret_rlast(io_ret_rlast), .io_ret_rerr(io_ret_rerr),
    .io_araddr(io_araddr), .io_arlen(io_arlen), .io_arsize(io_arsize),
    .io_arburst(io_arburst), .io_arvalid(io_arvalid), .io_arready(io_arready),
    .io_rdata(io_rdata), .io_rresp(io_rresp), .io_rvalid(io_rvalid),
    .io_rready(io_rready), .io_rlast(io_rlast), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && (io_i_rvalid || io_d_rvalid)) begin
      logic [DATA_W+2:0] exp, got;
      n_checks++;
      got = {io_d_rvalid, io_ret_rerr, io_ret_rlast, io_ret_rdata};
      if (io_i_rvalid) pulses_i++;
      if (io_i_rvalid && io_d_rvalid)
        $display("FAIL beat_both_owners i_rvalid=1 d_rvalid=1 expected only one");
      else if (exp_q.size() == 0)
        $display("FAIL beat_unexpected got=%h expected no beat", got);
      else begin
        exp = exp_q.pop_front();
        if (got !== exp) $display("FAIL beat got={d,err,last,data}=%h expected=%h", got, exp);
        else n_pass++;
      end
    end
  end

  // Driver tasks
  task automatic wait_cycle();
    @(posedge clock); #1;
  endtask

  task automatic send_beat(input logic is_d, input logic [DATA_W-1:0] data,
                           input logic last, input logic [1:0] resp, input logic err);
    exp_q.push_back({is_d, err, last, data});
    io_rvalid = 1'b1; io_rdata = data; io_rlast = last; io_rresp = resp;
    wait_cycle();
    io_rvalid = 1'b0; io_rlast = 1'b0; io_rresp = 2'b00;
  endtask

  // Requests from one side while IDLE, then completes the AR handshake at once.
  task automatic issue(input logic is_d, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    if (is_d) begin io_d_rreq = 1'b1; io_d_raddr = addr; io_d_rlen = len; end
    else      begin io_i_rreq = 1'b1; io_i_raddr = addr; io_i_rlen = len; end
    #1;
    n_checks++;
    if ({io_i_ack, io_d_ack} !== {!is_d, is_d})
      $display("FAIL issue_ack got i=%0b d=%0b expected i=%0b d=%0b", io_i_ack, io_d_ack, !is_d, is_d);
    else n_pass++;
    wait_cycle();
    io_i_rreq = 1'b0; io_d_rreq = 1'b0;
    n_checks++;
    if ({io_arvalid, io_araddr, io_arlen} !== {1'b1, addr, len})
      $display("FAIL issue_ar got v=%0b a=%h l=%0d expected v=1 a=%h l=%0d", io_arvalid, io_araddr, io_arlen, addr, len);
    else n_pass++;
    io_arready = 1'b1;
    wait_cycle();
    io_arready = 1'b0;
    n_checks++;
    if ({dbg_state, io_arvalid, io_rready} !== {2'd2, 1'b0, 1'b1})
      $display("FAIL issue_in_r got st=%0d arv=%0b rr=%0b expected st=2 arv=0 rr=1", dbg_state, io_arvalid, io_rready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) wait_cycle();
    n_checks++;
    if ({io_i_ack, io_d_ack, io_i_rvalid, io_d_rvalid, io_ret_rerr, io_arvalid, io_rready} !== 7'b0)
      $display("FAIL reset_ctrl got=%b expected=0000000",
               {io_i_ack, io_d_ack, io_i_rvalid, io_d_rvalid, io_ret_rerr, io_arvalid, io_rready});
    else n_pass++;
    n_checks++;
    if ({io_araddr, io_arlen, io_arsize, io_arburst, dbg_state} !== {32'h0, 8'h0, 3'b010, 2'b01, 2'd0})
      $display("FAIL reset_ar got a=%h l=%0d sz=%0d bu=%0d st=%0d expected a=0 l=0 sz=2 bu=1 st=0",
               io_araddr, io_arlen, io_arsize, io_arburst, dbg_state);
    else n_pass++;
    reset = 1'b0;
    wait_cycle();
  endtask

  task automatic test_icache_only();
    issue(1'b0, 32'h100, 8'd3);
    n_checks++;
    if ({io_arsize, io_arburst} !== {3'b010, 2'b01})
      $display("FAIL icache_size_burst got sz=%0d bu=%0d expected sz=2 bu=1", io_arsize, io_arburst);
    else n_pass++;
    for (int k = 0; k < 4; k++) send_beat(1'b0, 32'h40 + k, k == 3, 2'b00, 1'b0);
    n_checks++;
    if ({dbg_state, io_rready, exp_q.size() == 0} !== {2'd0, 1'b0, 1'b1})
      $display("FAIL icache_done got st=%0d rr=%0b qsize=%0d expected st=0 rr=0 qsize=0", dbg_state, io_rready, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_tie();
    reset = 1'b1; #2; reset = 1'b0;
    wait_cycle();
    io_i_rreq = 1'b1; io_i_raddr = 32'h100; io_i_rlen = 8'd1;
    io_d_rreq = 1'b1; io_d_raddr = 32'h200; io_d_rlen = 8'd1;
    #1;
    n_checks++;
    if ({io_i_ack, io_d_ack} !== 2'b01) $display("FAIL tie1_ack got i=%0b d=%0b expected i=0 d=1", io_i_ack, io_d_ack);
    else n_pass++;
    wait_cycle();
    io_d_raddr = 32'h240; io_d_rlen = 8'd0;  // dcache keeps rreq high for a new burst
    n_checks++;
    if ({io_araddr, io_i_ack, io_d_ack} !== {32'h200, 2'b00})
      $display("FAIL tie1_ar got a=%h i=%0b d=%0b expected a=200 i=0 d=0", io_araddr, io_i_ack, io_d_ack);
    else n_pass++;
    io_arready = 1'b1; wait_cycle(); io_arready = 1'b0;
    send_beat(1'b1, $urandom_range(0, 32'hffff), 1'b0, 2'b00, 1'b0);
    send_beat(1'b1, $urandom_range(0, 32'hffff), 1'b1, 2'b00, 1'b0);
    n_checks++;
    if ({dbg_state, io_i_ack, io_d_ack} !== {2'd0, 2'b10})
      $display("FAIL tie2_ack got st=%0d i=%0b d=%0b expected st=0 i=1 d=0", dbg_state, io_i_ack, io_d_ack);
    else n_pass++;
    wait_cycle();
    io_i_rreq = 1'b0;
    n_checks++;
    if ({io_araddr, io_arlen} !== {32'h100, 8'd1})
      $display("FAIL tie2_ar got a=%h l=%0d expected a=100 l=1", io_araddr, io_arlen);
    else n_pass++;
    io_arready = 1'b1; wait_cycle(); io_arready = 1'b0;
    send_beat(1'b0, $urandom_range(0, 32'hffff), 1'b0, 2'b00, 1'b0);
    send_beat(1'b0, $urandom_range(0, 32'hffff), 1'b1, 2'b00, 1'b0);
    n_checks++;
    if ({io_i_ack, io_d_ack} !== 2'b01) $display("FAIL tie3_ack got i=%0b d=%0b expected i=0 d=1", io_i_ack, io_d_ack);
    else n_pass++;
    wait_cycle();
    io_d_rreq = 1'b0;
    n_checks++;
    if ({io_araddr, io_arlen} !== {32'h240, 8'd0})
      $display("FAIL tie3_ar got a=%h l=%0d expected a=240 l=0", io_araddr, io_arlen);
    else n_pass++;
    io_arready = 1'b1; wait_cycle(); io_arready = 1'b0;
    send_beat(1'b1, $urandom_range(0, 32'hffff), 1'b1, 2'b00, 1'b0);
  endtask

  task automatic test_ar_stall();
    io_d_rreq = 1'b1; io_d_raddr = 32'h180; io_d_rlen = 8'd3;
    #1;
    n_checks++;
    if (io_d_ack !== 1'b1) $display("FAIL stall_ack got=%0b expected=1", io_d_ack);
    else n_pass++;
    wait_cycle();
    io_d_rreq = 1'b0;
    io_i_rreq = 1'b1; io_i_raddr = 32'h500; io_i_rlen = 8'd3;  // waits through AR and R
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({dbg_state, io_arvalid, io_araddr, io_arlen, io_i_ack, io_d_ack} !== {2'd1, 1'b1, 32'h180, 8'd3, 2'b00})
        $display("FAIL stall_hold c=%0d got st=%0d v=%0b a=%h l=%0d ack=%0b%0b expected st=1 v=1 a=180 l=3 ack=00",
                 c, dbg_state, io_arvalid, io_araddr, io_arlen, io_i_ack, io_d_ack);
      else n_pass++;
      wait_cycle();
    end
    io_arready = 1'b1; wait_cycle(); io_arready = 1'b0;
    n_checks++;
    if ({dbg_state, io_arvalid, io_i_ack} !== {2'd2, 1'b0, 1'b0})
      $display("FAIL stall_to_r got st=%0d v=%0b iack=%0b expected st=2 v=0 iack=0", dbg_state, io_arvalid, io_i_ack);
    else n_pass++;
    for (int k = 0; k < 4; k++) send_beat(1'b1, $urandom, k == 3, 2'b00, 1'b0);
  endtask

  task automatic test_rvalid_gaps();
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int k = 0;
    n_checks++;
    if (io_i_ack !== 1'b1) $display("FAIL gaps_ack got=%0b expected=1", io_i_ack);
    else n_pass++;
    wait_cycle();
    io_i_rreq = 1'b0;
    n_checks++;
    if (io_araddr !== 32'h500) $display("FAIL gaps_ar got a=%h expected a=500", io_araddr);
    else n_pass++;
    io_arready = 1'b1; wait_cycle(); io_arready = 1'b0;
    pulses_i = 0;
    for (int p = 0; p < 7; p++) begin
      if (pat[p] == 1) begin
        send_beat(1'b0, $urandom, k == 3, 2'b00, 1'b0);
        k++;
      end else begin
        #1;
        n_checks++;
        if (io_i_rvalid !== 1'b0) $display("FAIL gaps_idle p=%0d got=%0b expected=0", p, io_i_rvalid);
        else n_pass++;
        wait_cycle();
      end
    end
    n_checks++;
    if (pulses_i !== 4) $display("FAIL gaps_pulses got=%0d expected=4", pulses_i);
    else n_pass++;
  endtask

  task automatic test_errors();
    issue(1'b1, 32'h600, 8'd3);
    for (int k = 0; k < 4; k++) send_beat(1'b1, $urandom, k == 3, (k == 1) ? 2'b10 : 2'b00, k == 1);
    issue(1'b0, 32'h700, 8'd3);
    send_beat(1'b0, $urandom, 1'b0, 2'b00, 1'b0);
    send_beat(1'b0, $urandom, 1'b1, 2'b00, 1'b1);
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL err_short_idle got st=%0d expected st=0", dbg_state);
    else n_pass++;
    issue(1'b1, 32'h800, 8'd1);
    send_beat(1'b1, $urandom, 1'b0, 2'b00, 1'b0);
    send_beat(1'b1, $urandom, 1'b0, 2'b00, 1'b1);
    n_checks++;
    if (dbg_state !== 2'd2) $display("FAIL err_long_still_r got st=%0d expected st=2", dbg_state);
    else n_pass++;
    send_beat(1'b1, $urandom, 1'b1, 2'b00, 1'b1);
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL err_long_idle got st=%0d expected st=0", dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    issue(1'b1, 32'h900, 8'd3);
    send_beat(1'b1, $urandom, 1'b0, 2'b00, 1'b0);
    io_rvalid = 1'b1; io_rdata = 32'hdead;
    #1;
    n_checks++;
    if ({io_d_rvalid, io_rready} !== 2'b11) $display("FAIL rst_pre got dv=%0b rr=%0b expected 1 1", io_d_rvalid, io_rready);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({io_d_rvalid, io_rready, io_arvalid, dbg_state} !== {3'b000, 2'd0})
      $display("FAIL rst_async got dv=%0b rr=%0b av=%0b st=%0d expected 0 0 0 0", io_d_rvalid, io_rready, io_arvalid, dbg_state);
    else n_pass++;
    io_rvalid = 1'b0;
    wait_cycle();
    reset = 1'b0;
    wait_cycle();
    issue(1'b1, 32'h300, 8'd0);
    send_beat(1'b1, $urandom, 1'b1, 2'b00, 1'b0);
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL rst_after_idle got st=%0d expected st=0", dbg_state);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_tie();
    test_ar_stall();
    test_rvalid_gaps();
    test_errors();
    test_reset_mid_burst();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read channel of the cache subsystem between the instruction cache and the data cache refill engines.
- Accepts one burst request per requester, arbitrates between them, and issues exactly one AR transaction at a time.
- Steers returned R beats back to the granted requester.
- Sits inside the cache top, between both cache refill FSMs and the main-memory AXI slave.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, AXI data width; one beat is one word
LEN_W, 8, AXI burst length field width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
io_i_rreq  in  1  icache refill request; held until acked
io_i_raddr  in  ADDR_W  icache burst start address; line-aligned
io_i_rlen  in  LEN_W  icache burst length minus 1
io_i_ack  out  1  icache request consumed this cycle
io_i_rvalid  out  1  return beat valid for icache
io_d_rreq  in  1  dcache refill request; held until acked
io_d_raddr  in  ADDR_W  dcache burst start address
io_d_rlen  in  LEN_W  dcache burst length minus 1
io_d_ack  out  1  dcache request consumed this cycle
io_d_rvalid  out  1  return beat valid for dcache
io_ret_rdata  out  DATA_W  return beat data; shared by both requesters
io_ret_rlast  out  1  last beat of the burst
io_ret_rerr  out  1  beat has an error (bad rresp or length mismatch)
io_araddr  out  ADDR_W  AXI AR address
io_arlen  out  LEN_W  AXI AR length
io_arsize  out  3  constant 3'b010 (4 bytes)
io_arburst  out  2  constant 2'b01 (INCR)
io_arvalid  out  1  AXI AR valid
io_arready  in  1  AXI AR ready
io_rdata  in  DATA_W  AXI R data
io_rresp  in  2  AXI R response
io_rvalid  in  1  AXI R valid
io_rready  out  1  AXI R ready
io_rlast  in  1  AXI R last

Behaviour:
- FSM states are IDLE, AR and R. Reset forces IDLE immediately (async).
- Reset values:
  - all outputs 0, except io_arsize and io_arburst, which are constants;
  - last_grant = ICACHE, so the first tie goes to the dcache;
  - beat counter = 0; latched addr/len = 0.
- IDLE:
  - Winner when only one request is pending: that requester.
  - Winner when both are pending: the requester not in last_grant (round robin).
  - The winner's io_x_ack is combinational and high in that same IDLE cycle. Addr/len/owner are latched and the FSM goes to AR.
  - The requester deasserts rreq the cycle after ack, or keeps it high to request a new burst.
  - No request: stay in IDLE.
- AR:
  - io_arvalid=1 (registered). io_araddr/io_arlen come from the latch and stay stable until handshake.
  - On arvalid&&arready, go to R; arvalid is 0 from the next cycle.
  - Minimum latency: ack at cycle N, arvalid at N+1.
- R:
  - io_rready=1 (combinational in R only).
  - On each beat (rvalid&&rready):
    - owner's io_x_rvalid=1 in the same cycle (combinational);
    - io_ret_rdata=io_rdata and io_ret_rlast=io_rlast;
    - beat counter increments.
  - Non-owner rvalid is always 0. io_ret_* are don't-care when no beat is valid; drive them with io_rdata/io_rlast.
- Error flag io_ret_rerr is high on a beat if any of the following holds:
  - rresp!=0;
  - rlast=1 while count!=len;
  - rlast=0 while count>=len.
- Burst completion:
  - Complete only on the rlast beat. Then go to IDLE, set last_grant=owner, clear the counter.
  - IDLE always lasts at least one cycle between bursts.
  - Short burst (early rlast): flagged, ends immediately.
  - Long burst (missing rlast): extra beats are delivered, each flagged, until rlast.
- rvalid in IDLE or AR is ignored (rready=0).
- Request/ack rules:
  - Requests arriving in AR or R wait, with no ack; the requester must hold addr/len.
  - Ack is never given twice for one request.
- Counter width is LEN_W+1; it saturates at all-ones and does not wrap.
- Reset mid-operation:
  - All outputs drop asynchronously and the FSM returns to IDLE.
  - An outstanding AXI burst is abandoned; the system resets the slave concurrently.

Test Plan:
- icache only: rreq, raddr 0x100, rlen 3 -> ack in the same cycle. Next cycle: arvalid, araddr 0x100, arlen 3, arsize 2, arburst 1. R beats 0x40..0x43 appear on io_i_rvalid/ret_rdata, rlast on the 4th. io_d_rvalid stays 0 and rerr stays 0 throughout.
- Simultaneous requests right after reset: i 0x100, d 0x200 -> dcache acked first with araddr 0x200. Icache is granted after the burst, following one IDLE cycle. A second tie then goes to the icache.
- arready held low for 5 cycles -> arvalid/araddr/arlen stay stable. No second ack. The FSM moves to R on the handshake cycle.
- rvalid toggling 1,0,0,1,1,0,1 with rlen 3 -> exactly 4 io_x_rvalid pulses, aligned with rvalid, and rlast on the 4th.
- Error cases:
  - rresp=2 on beat 1 -> rerr on that beat only.
  - rlen 3 with rlast on beat 2 -> rerr, FSM returns to IDLE.
  - rlen 1 with no rlast until beat 3 -> beats 2 and 3 flagged, done on beat 3.
- reset pulsed mid-burst in R -> rready and io_x_rvalid drop without waiting for a clock edge. After release, a new dcache request to 0x300 is acked and issued normally.
